mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-access stage directly downstream of the ALU. Uses ALUResult as the byte address and ReadData2 as store data.
//  Runs a req/ack transaction on the data-memory bus and formats load data (lb/lh/lw/lbu/lhu) into MemData.
//  Stalls the pipeline until the access completes; flags misaligned or illegal accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT  255  max REQ cycles waiting for mem_ack before aborting (1..255)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  MemRead    in   1   current instruction is a load
//  MemWrite   in   1   current instruction is a store (priority over MemRead if both high)
//  ALUResult  in   32  byte address from ALU
//  ReadData2  in   32  store data (rs2)
//  funct3     in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  stall      out  1   combinational; holds upstream stages while high
//  done       out  1   one-cycle pulse: access finished (ok or error)
//  MemData    out  32  formatted load result, held until next load completes
//  misalign   out  1   one-cycle pulse with done: misaligned/illegal funct3
//  timeout    out  1   one-cycle pulse with done: no ack within TIMEOUT
//  mem_req    out  1   bus request, held until ack
//  mem_we     out  1   1=write, 0=read; valid while mem_req
//  mem_addr   out  32  word-aligned address {ALUResult[31:2],2'b00}
//  mem_wdata  out  32  lane-replicated store data
//  mem_be     out  4   byte enables (writes only; reads use 4'b1111)
//  mem_ack    in   1   bus completion; mem_rdata valid same cycle
//  mem_rdata  in   32  read data word
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, done, misalign, timeout = 0; mem_addr, mem_wdata, MemData = 0; mem_be = 0.
//  FSM IDLE -> REQ -> RESP -> IDLE; IDLE -> ERR -> IDLE; REQ -> ERR on timeout. All outputs except stall are registered.
//  IDLE: if MemRead|MemWrite: check alignment (h needs addr[0]=0, w needs addr[1:0]=0).
//   funct3 011/110/111, or 010 with MemRead... only 011,110,111 and 1xx on stores are illegal.
//   Illegal or misaligned -> ERR with no bus request. Otherwise latch addr/be/wdata/funct3; mem_req=1 next cycle; -> REQ.
//  REQ: outputs stable; wait counter increments per cycle. On mem_ack: latch mem_rdata -> RESP.
//   If counter reaches TIMEOUT without ack: drop mem_req -> ERR with timeout.
//   mem_req deasserts the cycle after ack.
//  RESP: done=1 for one cycle; loads update MemData, stores leave MemData unchanged -> IDLE.
//  ERR: done=1 plus misalign or timeout for one cycle; MemData unchanged; -> IDLE.
//  stall = (IDLE & (MemRead|MemWrite)) | REQ. Low in RESP/ERR, so upstream advances at that edge; no re-trigger.
//  Latency: request presented cycle 0, ack in cycle 1 -> done in cycle 2; each extra wait cycle adds 1.
//  Store lanes: b: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; h: wdata={2{rs2[15:0]}}, be=addr[1]?1100:0011; w: be=1111.
//  Load format: select byte/half by addr[1:0]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes word.
//  mem_ack outside REQ is ignored. rst mid-transaction: immediate IDLE, mem_req=0, no done pulse; late ack ignored.
// TESTING
//  1 lw addr 0x100, ack cycle 1, rdata 0xDEADBEEF -> mem_req cycles 1; done cycle 2; MemData=0xDEADBEEF; stall 0..1.
//  2 lb addr 0x103, rdata 0x80FF1234 -> MemData=0xFFFFFF80; lbu same -> 0x00000080.
//  3 sh addr 0x102, rs2 0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100; MemData unchanged.
//  4 lw addr 0x101 -> mem_req never asserted; done+misalign pulse in cycle 1; stall high cycle 0 only.
//  5 TIMEOUT=4, lw with ack never asserted -> mem_req high 4 cycles, then done+timeout pulse; next load proceeds normally.
//  6 rst asserted during REQ (ack held off) -> mem_req=0 async; ack next cycle ignored; no done; MemData=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage with req/ack bus, load formatting and error detection
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        done,
    output logic [31:0] MemData,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    state_t state, next;
    logic [7:0] cnt;
    logic [2:0] f3;
    logic [1:0] off;
    logic go, bad, expired;
    logic [3:0] be_n;
    logic [31:0] wdata_n, shifted, ld;
    logic [15:0] half;
    // request decode, legality/alignment check, store lane steering and next state
    always_comb begin
        go = MemRead | MemWrite;
        bad = (funct3 == 3'b011) | (funct3[2] & funct3[1]) | (MemWrite & funct3[2])
            | ((funct3[1:0] == 2'b01) & ALUResult[0])
            | ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));
        expired = cnt == 8'(TIMEOUT - 1);
        wdata_n = funct3[1:0] == 2'b00 ? {4{ReadData2[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{ReadData2[15:0]}} : ReadData2;
        be_n = !MemWrite ? 4'b1111 :
               funct3[1:0] == 2'b00 ? 4'b0001 << ALUResult[1:0] :
               funct3[1:0] == 2'b01 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        next = state;
        case (state)
            IDLE: next = go ? (bad ? ERR : REQ) : IDLE;
            REQ:  next = mem_ack ? RESP : (expired ? ERR : REQ);
            default: next = IDLE;
        endcase
        stall = ((state == IDLE) & go) | (state == REQ);
    end
    // load formatting from the word on the bus using the latched offset and size
    always_comb begin
        shifted = mem_rdata >> {off, 3'b000};
        half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld = f3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
             f3 == 3'b001 ? {{16{half[15]}}, half} :
             f3 == 3'b100 ? {24'd0, shifted[7:0]} :
             f3 == 3'b101 ? {16'd0, half} : mem_rdata;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // registered bus outputs, status pulses and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            MemData   <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
            f3        <= '0;
            off       <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
            if (state == IDLE && go) begin
                if (bad) begin
                    done     <= 1'b1;
                    misalign <= 1'b1;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWrite;
                    mem_addr  <= {ALUResult[31:2], 2'b00};
                    mem_wdata <= wdata_n;
                    mem_be    <= be_n;
                    f3        <= funct3;
                    off       <= ALUResult[1:0];
                    cnt       <= '0;
                end
            end else if (state == REQ) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    done    <= 1'b1;
                    if (!mem_we) MemData <= ld;
                end else if (expired) begin
                    mem_req <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, stores, errors, timeout and reset abort
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] ALUResult, ReadData2;
    logic [2:0]  funct3;
    logic        stall, done, misalign, timeout;
    logic [31:0] MemData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    int total = 0;
    int bad = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .ReadData2(ReadData2), .funct3(funct3),
        .stall(stall), .done(done), .MemData(MemData), .misalign(misalign),
        .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd, input int waits);
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; ALUResult = a; funct3 = f;
        repeat (waits + 1) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; MemRead = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; ReadData2 = '0;
        funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst done", done, 0);
        chk("rst misalign", misalign, 0);
        chk("rst timeout", timeout, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_be", mem_be, 0);
        chk("rst MemData", MemData, 0);
        chk("rst stall", stall, 0);
        rst = 1'b0;
        // lw 0x100, ack in cycle 1
        @(negedge clk);
        MemRead = 1'b1; ALUResult = 32'h100; funct3 = 3'b010;
        #1 chk("t1 stall c0", stall, 1);
        chk("t1 req c0", mem_req, 0);
        @(negedge clk);
        chk("t1 req c1", mem_req, 1);
        chk("t1 we c1", mem_we, 0);
        chk("t1 addr c1", mem_addr, 32'h100);
        chk("t1 be c1", mem_be, 4'b1111);
        chk("t1 stall c1", stall, 1);
        chk("t1 done c1", done, 0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t1 req c2", mem_req, 0);
        chk("t1 done c2", done, 1);
        chk("t1 data c2", MemData, 32'hDEADBEEF);
        chk("t1 stall c2", stall, 0);
        MemRead = 1'b0;
        @(negedge clk);
        chk("t1 done c3", done, 0);
        // lb / lbu at byte 3
        load(3'b000, 32'h103, 32'h80FF1234, 0);
        chk("t2 lb done", done, 1);
        chk("t2 lb data", MemData, 32'hFFFFFF80);
        load(3'b100, 32'h103, 32'h80FF1234, 0);
        chk("t2 lbu data", MemData, 32'h00000080);
        // sh 0x102
        @(negedge clk);
        MemWrite = 1'b1; ALUResult = 32'h102; ReadData2 = 32'h0000ABCD; funct3 = 3'b001;
        @(negedge clk);
        chk("t3 req", mem_req, 1);
        chk("t3 we", mem_we, 1);
        chk("t3 be", mem_be, 4'b1100);
        chk("t3 wdata", mem_wdata, 32'hABCDABCD);
        chk("t3 addr", mem_addr, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0; MemWrite = 1'b0;
        chk("t3 done", done, 1);
        chk("t3 data kept", MemData, 32'h00000080);
        // sb 0x101 lane steering
        @(negedge clk);
        MemWrite = 1'b1; ALUResult = 32'h101; ReadData2 = 32'h123456A5; funct3 = 3'b000;
        @(negedge clk);
        chk("sb be", mem_be, 4'b0010);
        chk("sb wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; MemWrite = 1'b0;
        chk("sb done", done, 1);
        // lw 0x101 misaligned
        @(negedge clk);
        MemRead = 1'b1; ALUResult = 32'h101; funct3 = 3'b010;
        #1 chk("t4 stall c0", stall, 1);
        @(negedge clk);
        chk("t4 req c1", mem_req, 0);
        chk("t4 done c1", done, 1);
        chk("t4 misalign c1", misalign, 1);
        chk("t4 stall c1", stall, 0);
        MemRead = 1'b0;
        @(negedge clk);
        chk("t4 done c2", done, 0);
        chk("t4 misalign c2", misalign, 0);
        // store with funct3 100 is illegal
        @(negedge clk);
        MemWrite = 1'b1; ALUResult = 32'h200; funct3 = 3'b100;
        @(negedge clk);
        chk("ill st req", mem_req, 0);
        chk("ill st misalign", misalign, 1);
        MemWrite = 1'b0;
        // lw with no ack -> timeout after 4 request cycles
        @(negedge clk);
        MemRead = 1'b1; ALUResult = 32'h200; funct3 = 3'b010;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5 req c%0d", i), mem_req, 1);
            chk($sformatf("t5 done c%0d", i), done, 0);
        end
        @(negedge clk);
        chk("t5 req c5", mem_req, 0);
        chk("t5 done c5", done, 1);
        chk("t5 timeout c5", timeout, 1);
        chk("t5 misalign c5", misalign, 0);
        chk("t5 data kept", MemData, 32'h00000080);
        MemRead = 1'b0;
        load(3'b010, 32'h204, 32'h12345678, 1);
        chk("t5 next done", done, 1);
        chk("t5 next timeout", timeout, 0);
        chk("t5 next data", MemData, 32'h12345678);
        load(3'b101, 32'h206, 32'h8001BEEF, 0);
        chk("lhu data", MemData, 32'h00008001);
        load(3'b001, 32'h206, 32'h8001BEEF, 0);
        chk("lh data", MemData, 32'hFFFF8001);
        // reset during REQ
        @(negedge clk);
        MemRead = 1'b1; ALUResult = 32'h300; funct3 = 3'b010;
        @(negedge clk);
        chk("t6 req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1; MemRead = 1'b0;
        #1 chk("t6 req async", mem_req, 0);
        chk("t6 stall", stall, 0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t6 done", done, 0);
        chk("t6 req", mem_req, 0);
        chk("t6 data", MemData, 0);
        @(negedge clk);
        chk("t6 done late", done, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
